// File: rtl/cp0_regs.sv
// CP0 system control registers: BadVAddr, Count, Compare, Status, Cause and EPC.
// Exceptions, ERET and MTC0 writes arrive already committed and are applied in
// priority order exc_valid > eret > wen. Reads are combinational from the flops.
module cp0_regs #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [5:0]  ext_int,
    output logic [7:0]  interrupt_info,
    output logic [31:0] cp0_status,
    output logic [31:0] epc
);

    localparam logic [4:0] AddrBadVAddr = 5'd8;
    localparam logic [4:0] AddrCount    = 5'd9;
    localparam logic [4:0] AddrCompare  = 5'd11;
    localparam logic [4:0] AddrStatus   = 5'd12;
    localparam logic [4:0] AddrCause    = 5'd13;
    localparam logic [4:0] AddrEpc      = 5'd14;

    // Last phase value before Count advances; a 1-bit phase covers COUNT_DIV of 1 and 2.
    localparam logic PhaseMax = 1'(COUNT_DIV - 1);

    // Status fields
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    // Full-width registers
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        phase_q, phase_d;

    logic        tick;
    logic [31:0] status_word;
    logic [31:0] cause_word;

    // Next-state: timer/interrupt sampling every cycle, then the single winning event.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;

        tick    = (phase_q == PhaseMax);
        phase_d = tick ? 1'b0 : phase_q + 1'b1;
        count_d = tick ? count_q + 32'd1 : count_q;

        // Timer interrupt folds into HW5 using the registered TI.
        ip_hw_d = {ext_int[5] | ti_q, ext_int[4:0]};
        ti_d    = ti_q | (count_q == compare_q);

        if (exc_valid) begin
            // A nested exception keeps the original return address.
            if (!exl_q) begin
                epc_d = exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                bd_d  = exc_in_delay_slot;
            end
            exl_d      = 1'b1;
            exc_code_d = exc_code;
            if (exc_code == 5'h04 || exc_code == 5'h05) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (wen) begin
            case (waddr)
                AddrCount: count_d = wdata;
                AddrCompare: begin
                    compare_d = wdata;
                    ti_d      = 1'b0;
                end
                AddrStatus: begin
                    im_d  = wdata[15:8];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                AddrCause: ip_sw_d = wdata[9:8];
                AddrEpc:   epc_d   = wdata;
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            phase_q    <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            phase_q    <= phase_d;
        end
    end

    // Register views and MFC0 read mux; BEV is hardwired to 1.
    always_comb begin
        status_word = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
        cause_word  = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'd0};

        case (raddr)
            AddrBadVAddr: rdata = badvaddr_q;
            AddrCount:    rdata = count_q;
            AddrCompare:  rdata = compare_q;
            AddrStatus:   rdata = status_word;
            AddrCause:    rdata = cause_word;
            AddrEpc:      rdata = epc_q;
            default:      rdata = 32'd0;
        endcase

        cp0_status     = status_word;
        epc            = epc_q;
        interrupt_info = {ip_hw_q, ip_sw_q} & im_q;
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a word-level register model.
module tb_cp0_regs;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [5:0]  ext_int;
    logic [7:0]  interrupt_info;
    logic [31:0] cp0_status;
    logic [31:0] epc;

    cp0_regs #(.COUNT_DIV(DIV)) dut (
        .clk               (clk),
        .reset             (reset),
        .exc_valid         (exc_valid),
        .exc_code          (exc_code),
        .exc_pc            (exc_pc),
        .exc_in_delay_slot (exc_in_delay_slot),
        .exc_badvaddr      (exc_badvaddr),
        .eret              (eret),
        .wen               (wen),
        .waddr             (waddr),
        .wdata             (wdata),
        .raddr             (raddr),
        .rdata             (rdata),
        .ext_int           (ext_int),
        .interrupt_info    (interrupt_info),
        .cp0_status        (cp0_status),
        .epc               (epc)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model: whole register words, updated per the CP0 rules.
    logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare;
    int          m_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] n_cause, n_count;
        logic        ti;
        if (reset) begin
            m_status = 32'h0040_0000;
            m_cause = 0; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0; m_phase = 0;
            return;
        end
        n_count = ((m_phase % DIV) == DIV - 1) ? m_count + 1 : m_count;
        m_phase++;
        ti = m_cause[30] | (m_count == m_compare);
        n_cause = m_cause;
        n_cause[15:10] = {ext_int[5] | m_cause[30], ext_int[4:0]};
        if (exc_valid) begin
            if (!m_status[1]) begin
                m_epc = exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                n_cause[31] = exc_in_delay_slot;
            end
            m_status[1] = 1'b1;
            n_cause[6:2] = exc_code;
            if (exc_code == 5'd4 || exc_code == 5'd5) m_bad = exc_badvaddr;
        end else if (eret) begin
            m_status[1] = 1'b0;
        end else if (wen) begin
            case (waddr)
                5'd9:  n_count = wdata;
                5'd11: begin m_compare = wdata; ti = 1'b0; end
                5'd12: m_status = (wdata & 32'h0000_FF03) | 32'h0040_0000;
                5'd13: n_cause[9:8] = wdata[9:8];
                5'd14: m_epc = wdata;
                default: ;
            endcase
        end
        n_cause[30] = ti;
        m_cause = n_cause;
        m_count = n_count;
    endtask

    // Per-cycle comparison of every output and every register against the model.
    task automatic compare_all();
        logic [4:0] addrs [7];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'($urandom_range(0, 31))};
        check("cp0_status", cp0_status, m_status);
        check("epc", epc, m_epc);
        check("interrupt_info", {24'd0, interrupt_info}, {24'd0, m_cause[15:8] & m_status[15:8]});
        foreach (addrs[i]) begin
            raddr = addrs[i];
            #1;
            check($sformatf("rdata[%0d]", addrs[i]), rdata, mread(addrs[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        reset = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_in_delay_slot = 0;
        exc_badvaddr = 0; eret = 0; wen = 0; waddr = 0; wdata = 0; ext_int = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        wen = 1; waddr = a; wdata = d;
        cycle();
        idle();
    endtask

    task automatic expect_reg(input string name, input logic [4:0] a, input logic [31:0] mask,
                              input logic [31:0] exp);
        raddr = a;
        #1;
        check(name, rdata & mask, exp);
    endtask

    initial begin
        bit found;
        idle();
        raddr = 0;
        reset = 1;
        cycle();
        reset = 0;
        check("rst_status", cp0_status, 32'h0040_0000);
        check("rst_epc", epc, 32'd0);
        check("rst_info", {24'd0, interrupt_info}, 32'd0);
        expect_reg("rst_cause", 5'd13, 32'hFFFF_FFFF, 32'd0);
        expect_reg("rst_count", 5'd9, 32'hFFFF_FFFF, 32'd0);

        // Non-slot address-error exception.
        exc_valid = 1; exc_code = 5'h04; exc_pc = 32'hBFC0_0100; exc_badvaddr = 32'h3;
        cycle();
        idle();
        check("exc_epc", epc, 32'hBFC0_0100);
        check("exc_status", cp0_status, 32'h0040_0002);
        expect_reg("exc_bd_code", 5'd13, 32'h8000_007C, 32'h0000_0010);
        expect_reg("exc_badvaddr", 5'd8, 32'hFFFF_FFFF, 32'h3);

        // Nested exception in a delay slot while EXL is set.
        exc_valid = 1; exc_code = 5'h08; exc_pc = 32'h8000_1004; exc_in_delay_slot = 1;
        exc_badvaddr = 32'hDEAD_BEEF;
        cycle();
        idle();
        check("nest_epc", epc, 32'hBFC0_0100);
        check("nest_exl", cp0_status, 32'h0040_0002);
        expect_reg("nest_bd_code", 5'd13, 32'h8000_007C, 32'h0000_0020);
        expect_reg("nest_badvaddr", 5'd8, 32'hFFFF_FFFF, 32'h3);

        // Exception, ERET and MTC0 EPC in one cycle: only the exception acts.
        exc_valid = 1; exc_code = 5'h00; exc_pc = 32'h100; eret = 1;
        wen = 1; waddr = 5'd14; wdata = 32'h1234;
        cycle();
        idle();
        check("prio_epc", epc, 32'hBFC0_0100);
        check("prio_exl", cp0_status, 32'h0040_0002);
        eret = 1;
        cycle();
        idle();
        check("eret_exl", cp0_status, 32'h0040_0000);

        // Timer interrupt through IM7.
        mtc0(5'd12, 32'h0000_8000);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd5);
        found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            cycle();
            if (interrupt_info[7]) found = 1;
        end
        check("timer_irq_seen", {31'd0, found}, 32'd1);
        check("timer_info", {24'd0, interrupt_info}, 32'h80);
        expect_reg("timer_ti", 5'd13, 32'h4000_0000, 32'h4000_0000);
        mtc0(5'd11, 32'h100);
        expect_reg("timer_ti_clr", 5'd13, 32'h4000_0000, 32'd0);

        // Count wrap and write-over-increment.
        mtc0(5'd9, 32'hFFFF_FFFF);
        expect_reg("count_load", 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        found = 0;
        for (int i = 0; i < 3 && !found; i++) begin
            cycle();
            raddr = 5'd9;
            #1;
            if (rdata != 32'hFFFF_FFFF) found = 1;
        end
        check("count_wrap", rdata, 32'd0);
        mtc0(5'd9, 32'h55);
        expect_reg("count_wr0", 5'd9, 32'hFFFF_FFFF, 32'h55);
        mtc0(5'd9, 32'hAA);
        expect_reg("count_wr1", 5'd9, 32'hFFFF_FFFF, 32'hAA);

        // Write masks.
        mtc0(5'd12, 32'hFFFF_FFFF);
        expect_reg("status_mask", 5'd12, 32'hFFFF_FFFF, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_reg("cause_mask", 5'd13, 32'hFFFF_FF00, 32'h0000_0300);
        mtc0(5'd8, 32'h1111_1111);
        expect_reg("badvaddr_ro", 5'd8, 32'hFFFF_FFFF, 32'h3);

        // Reset beats simultaneous events.
        reset = 1; exc_valid = 1; exc_code = 5'h05; exc_badvaddr = 32'h77;
        wen = 1; waddr = 5'd12; wdata = 32'hFFFF_FFFF; ext_int = 6'h3F;
        cycle();
        idle();
        check("mrst_status", cp0_status, 32'h0040_0000);
        check("mrst_info", {24'd0, interrupt_info}, 32'd0);
        expect_reg("mrst_cause", 5'd13, 32'hFFFF_FFFF, 32'd0);
        expect_reg("mrst_bad", 5'd8, 32'hFFFF_FFFF, 32'd0);
        expect_reg("mrst_compare", 5'd11, 32'hFFFF_FFFF, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            reset = ($urandom_range(0, 127) == 0);
            exc_valid = ($urandom_range(0, 7) == 0);
            exc_code = ($urandom_range(0, 1) == 1) ? 5'(4 + $urandom_range(0, 1))
                                                   : 5'($urandom);
            exc_pc = $urandom;
            exc_in_delay_slot = 1'($urandom);
            exc_badvaddr = $urandom;
            eret = ($urandom_range(0, 7) == 0);
            wen = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 6))
                0: waddr = 5'd8;
                1: waddr = 5'd9;
                2: waddr = 5'd11;
                3: waddr = 5'd12;
                4: waddr = 5'd13;
                5: waddr = 5'd14;
                default: waddr = 5'($urandom);
            endcase
            wdata = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + $urandom_range(0, 6);
            if (waddr == 5'd9 && $urandom_range(0, 1) == 1) wdata = m_compare - $urandom_range(0, 4);
            ext_int = 6'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
